player_motion_controller: RTL
=============================

# player_motion_controller

Per-frame motion and life-cycle controller for the player car. It generalises the fixed single-car controller into a parametrised block with:
- configurable coordinate width, road bounds, sprite geometry and death-animation length;
- a speed model driven by the gas input;
- symmetric wall deaths and external collision deaths;
- an explicit alive/dying/respawn state machine.

It sits between the keyboard/collision logic and the sprite state table that feeds the VGA drawing pipeline.

## Interface
Parameters:
- COORD_W, 11, width of every sprite-state field
- X_MIN, 242, leftmost legal x (inclusive)
- X_MAX, 484, right road edge; legal while x+CAR_W <= X_MAX
- X_START, 256, x after reset and after respawn
- Y_START, 380, fixed y
- CAR_W / CAR_H, 32 / 36, alive sprite size
- DEATH_W / DEATH_H, 64 / 64, sprite size during death animation
- DEATH_IMG_BASE, 99, img_id of first death frame
- DEATH_FRAMES, 12, number of death images
- FRAMES_PER_IMG, 16, frames each death image is held
- MAX_SPEED, 7, speed saturation value
- ACCEL_DIV, 8, frames per speed step
- RESPAWN_FRAMES, 120, invulnerable frames after respawn (used only with macro)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse per video frame; all state updates happen only on these cycles
- left_pressed / right_pressed / gas_pressed  in  1 each  level inputs
- collision  in  1  pulse or level from the collision detector
- player_state  out  [0:4][0:COORD_W-1]  {img_id, x, y, width, height}
- speed  out  $clog2(MAX_SPEED+1)  current speed
- dying  out  1  high while in DYING
- invulnerable  out  1  high while in RESPAWN

## Operation
- FSM states: ALIVE, DYING, RESPAWN.
- Collision latch:
  - Set on any cycle with collision=1 while in ALIVE.
  - Consumed and cleared on the next frame_start.
  - Cleared on entry to DYING.
- ALIVE, per frame:
  - Steering:
    - Exactly one of left/right pressed. Right: x+1 if x+CAR_W < X_MAX; death if x+CAR_W == X_MAX. Left: x-1 if x > X_MIN; death if x == X_MIN.
    - Both or neither pressed: x unchanged.
  - Speed: accel counter increments every frame and wraps at ACCEL_DIV-1. On wrap, speed+1 (saturating at MAX_SPEED) if gas held, else speed-1 (saturating at 0).
  - Latched collision or wall death → DYING. Death takes priority over the move in the same frame. Collision plus wall death in one frame produces exactly one death.
- DYING:
  - Entry: anim counter=0, speed=0, accel counter=0.
  - Each frame the counter increments. img_id = DEATH_IMG_BASE + counter/FRAMES_PER_IMG; width/height = DEATH_W/DEATH_H.
  - Inputs and collision are ignored.
  - On the frame the counter reaches DEATH_FRAMES*FRAMES_PER_IMG-1: x=X_START, img_id=0, size=CAR_W/CAR_H, then go to RESPAWN (macro on) or ALIVE (macro off).
- RESPAWN:
  - Steering and speed behave as in ALIVE.
  - Collision is ignored and never latched.
  - Wall deaths are still active.
  - Leaves to ALIVE after RESPAWN_FRAMES frames.
- Arithmetic:
  - All x math is unsigned COORD_W. Compute x+CAR_W with one extra bit so it cannot overflow.
  - Divisions by parameters resolve at elaboration; FRAMES_PER_IMG a power of two is preferred but not required.

## Timing
- Reset (async, any time, including mid-DYING):
  - player_state={0, X_START, Y_START, CAR_W, CAR_H}, speed=0, dying=0, invulnerable=0.
  - FSM=ALIVE; all counters and the latch cleared.
- Outputs are registered and updated on the frame_start edge itself. The new state is visible the cycle after frame_start, with no extra frame of lag.
- Between frame_start pulses all outputs hold.
- dying and invulnerable change on the same edge as the FSM state.
- A collision arriving on the frame_start cycle itself is latched and acted on at the following frame_start.
- Death animation length: DEATH_FRAMES*FRAMES_PER_IMG frames (192 by default).

## Configuration
- PLAYER_RESPAWN_BLINK_EN:
  - Defined: RESPAWN state exists, invulnerable is driven. On odd 8-frame periods of RESPAWN, img_id is forced to all-ones (transparent sprite) to blink the car.
  - Undefined: DYING goes directly to ALIVE, invulnerable is tied 0, no RESPAWN_FRAMES counter is built.

## Test plan
- Reset mid-DYING (counter=50) → next cycle state={0,256,380,32,36}, dying=0, speed=0.
- Right held from reset for 196 frames → x reaches 452 (452+32=484); the next frame enters DYING with img_id=99; 16 frames later img_id=100.
- Full death sequence → after 192 frames x=256, img_id=0, width=32; invulnerable=1 for 120 frames if the macro is defined, else 0.
- Gas held 64 frames → speed=7 at frame 56 and stays 7; release → speed reaches 0 after 56 frames.
- One-cycle collision pulse mid-frame in ALIVE → DYING at the next frame_start; same pulse during RESPAWN → ignored.
- Left+right held together at x=300 → x stays 300; collision and wall death in the same frame → single DYING entry, counter=0.

Source files
------------

// File: rtl/player_motion_controller_if.sv
// Interface bundling the frame/control inputs and sprite-state outputs
// of the player motion controller: master drives controls, slave is the controller.
interface player_motion_controller_if #(
    parameter int COORD_W = 11,
    parameter int SPD_W   = 3
);
    logic                      frame_start;
    logic                      left_pressed;
    logic                      right_pressed;
    logic                      gas_pressed;
    logic                      collision;
    logic [0:4][0:COORD_W-1]   player_state;
    logic [SPD_W-1:0]          speed;
    logic                      dying;
    logic                      invulnerable;

    modport master (
        output frame_start, left_pressed, right_pressed, gas_pressed, collision,
        input  player_state, speed, dying, invulnerable
    );

    modport slave (
        input  frame_start, left_pressed, right_pressed, gas_pressed, collision,
        output player_state, speed, dying, invulnerable
    );
endinterface

// File: rtl/player_motion_controller.sv
// Per-frame player car motion, speed and death/respawn sequencing.
// Ports: clk, resetN (async low); bus (slave): frame_start, left/right/gas_pressed,
// collision in; player_state {img,x,y,w,h}, speed, dying, invulnerable out.
// Option macro PLAYER_RESPAWN_BLINK_EN: adds blinking invulnerable RESPAWN state.
module player_motion_controller #(
    parameter int COORD_W        = 11,
    parameter int X_MIN          = 242,
    parameter int X_MAX          = 484,
    parameter int X_START        = 256,
    parameter int Y_START        = 380,
    parameter int CAR_W          = 32,
    parameter int CAR_H          = 36,
    parameter int DEATH_W        = 64,
    parameter int DEATH_H        = 64,
    parameter int DEATH_IMG_BASE = 99,
    parameter int DEATH_FRAMES   = 12,
    parameter int FRAMES_PER_IMG = 16,
    parameter int MAX_SPEED      = 7,
    parameter int ACCEL_DIV      = 8,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic clk,
    input  logic resetN,
    player_motion_controller_if.slave bus
);
    localparam int SPD_W     = $clog2(MAX_SPEED + 1);
    localparam int DEATH_LEN = DEATH_FRAMES * FRAMES_PER_IMG;
    localparam int ANIM_W    = (DEATH_LEN > 1) ? $clog2(DEATH_LEN) : 1;
    localparam int ACC_W     = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_e_t;
    typedef logic [SPD_W-1:0]   spd_t;
    typedef logic [ACC_W-1:0]   acc_t;
    typedef logic [ANIM_W-1:0]  anim_t;

    localparam coord_t   XMIN_C    = coord_t'(X_MIN);
    localparam coord_e_t XMAX_C    = coord_e_t'(X_MAX);
    localparam coord_e_t CARW_E    = coord_e_t'(CAR_W);
    localparam coord_t   XSTART_C  = coord_t'(X_START);
    localparam coord_t   CARW_C    = coord_t'(CAR_W);
    localparam coord_t   CARH_C    = coord_t'(CAR_H);
    localparam coord_t   DW_C      = coord_t'(DEATH_W);
    localparam coord_t   DH_C      = coord_t'(DEATH_H);
    localparam coord_t   DBASE_C   = coord_t'(DEATH_IMG_BASE);
    localparam spd_t     SPDMAX_C  = spd_t'(MAX_SPEED);
    localparam acc_t     ACCLAST_C = acc_t'(ACCEL_DIV - 1);
    localparam anim_t    ANIMLAST_C = anim_t'(DEATH_LEN - 1);

    typedef enum logic [1:0] {ST_ALIVE, ST_DYING, ST_RESPAWN} state_e;

    state_e state_q;
    coord_t x_q, img_q, w_q, h_q;
    spd_t   spd_q;
    acc_t   acc_q;
    anim_t  anim_q;
    logic   coll_q;
    logic   dying_q;

    logic     steer_r, steer_l, wall_hit;
    coord_e_t x_end;
    coord_t   x_d, img_anim;
    spd_t     spd_d;
    acc_t     acc_d;
    anim_t    anim_d;

    assign steer_r  = bus.right_pressed & ~bus.left_pressed;
    assign steer_l  = bus.left_pressed & ~bus.right_pressed;
    // One extra bit so x+CAR_W never wraps.
    assign x_end    = {1'b0, x_q} + CARW_E;
    assign wall_hit = (steer_r && x_end == XMAX_C) || (steer_l && x_q == XMIN_C);
    assign anim_d   = anim_q + anim_t'(1);
    assign img_anim = coord_t'(DEATH_IMG_BASE + int'(anim_d) / FRAMES_PER_IMG);

    // Move and speed step shared by ALIVE and RESPAWN.
    always_comb begin
        x_d   = x_q;
        spd_d = spd_q;
        acc_d = acc_q + acc_t'(1);
        if (steer_r && x_end < XMAX_C) begin
            x_d = x_q + coord_t'(1);
        end else if (steer_l && x_q > XMIN_C) begin
            x_d = x_q - coord_t'(1);
        end
        if (acc_q == ACCLAST_C) begin
            acc_d = '0;
            if (bus.gas_pressed && spd_q < SPDMAX_C) begin
                spd_d = spd_q + spd_t'(1);
            end else if (!bus.gas_pressed && spd_q != '0) begin
                spd_d = spd_q - spd_t'(1);
            end
        end
    end

`ifdef PLAYER_RESPAWN_BLINK_EN
    localparam int RESP_W = ($clog2(RESPAWN_FRAMES) > 4) ? $clog2(RESPAWN_FRAMES) : 4;
    typedef logic [RESP_W-1:0] resp_t;
    localparam resp_t RESPLAST_C = resp_t'(RESPAWN_FRAMES - 1);
    resp_t resp_q, resp_d;
    logic  inv_q;
    assign resp_d = resp_q + resp_t'(1);
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_ALIVE;
            x_q     <= XSTART_C;
            img_q   <= '0;
            w_q     <= CARW_C;
            h_q     <= CARH_C;
            spd_q   <= '0;
            acc_q   <= '0;
            anim_q  <= '0;
            coll_q  <= 1'b0;
            dying_q <= 1'b0;
`ifdef PLAYER_RESPAWN_BLINK_EN
            resp_q  <= '0;
            inv_q   <= 1'b0;
`endif
        end else if (!bus.frame_start) begin
            if (state_q == ST_ALIVE && bus.collision) coll_q <= 1'b1;
        end else begin
            unique case (state_q)
                ST_ALIVE, ST_RESPAWN: begin
                    if (wall_hit || (state_q == ST_ALIVE && coll_q)) begin
                        state_q <= ST_DYING;
                        dying_q <= 1'b1;
                        anim_q  <= '0;
                        spd_q   <= '0;
                        acc_q   <= '0;
                        coll_q  <= 1'b0;
                        img_q   <= DBASE_C;
                        w_q     <= DW_C;
                        h_q     <= DH_C;
`ifdef PLAYER_RESPAWN_BLINK_EN
                        inv_q   <= 1'b0;
                        resp_q  <= '0;
`endif
                    end else begin
                        x_q    <= x_d;
                        spd_q  <= spd_d;
                        acc_q  <= acc_d;
                        // A collision on the frame_start cycle itself is kept for next frame.
                        coll_q <= (state_q == ST_ALIVE) && bus.collision;
`ifdef PLAYER_RESPAWN_BLINK_EN
                        if (state_q == ST_RESPAWN) begin
                            if (resp_q == RESPLAST_C) begin
                                state_q <= ST_ALIVE;
                                inv_q   <= 1'b0;
                                resp_q  <= '0;
                                img_q   <= '0;
                            end else begin
                                resp_q <= resp_d;
                                // Odd 8-frame periods show the transparent image.
                                img_q  <= resp_d[3] ? '1 : '0;
                            end
                        end
`endif
                    end
                end
                ST_DYING: begin
                    if (anim_q == ANIMLAST_C) begin
                        x_q     <= XSTART_C;
                        img_q   <= '0;
                        w_q     <= CARW_C;
                        h_q     <= CARH_C;
                        anim_q  <= '0;
                        dying_q <= 1'b0;
`ifdef PLAYER_RESPAWN_BLINK_EN
                        state_q <= ST_RESPAWN;
                        inv_q   <= 1'b1;
                        resp_q  <= '0;
`else
                        state_q <= ST_ALIVE;
`endif
                    end else begin
                        anim_q <= anim_d;
                        img_q  <= img_anim;
                    end
                end
                default: state_q <= ST_ALIVE;
            endcase
        end
    end

    assign bus.player_state[0] = img_q;
    assign bus.player_state[1] = x_q;
    assign bus.player_state[2] = coord_t'(Y_START);
    assign bus.player_state[3] = w_q;
    assign bus.player_state[4] = h_q;
    assign bus.speed           = spd_q;
    assign bus.dying           = dying_q;
`ifdef PLAYER_RESPAWN_BLINK_EN
    assign bus.invulnerable    = inv_q;
`else
    // No RESPAWN state here; the compare only keeps RESPAWN_FRAMES referenced.
    assign bus.invulnerable    = 1'b0 & (RESPAWN_FRAMES < 0);
`endif
endmodule
